// File: rtl/mult_pipe_dw.sv
// mult_pipe_dw: DW x DW pipelined integer multiplier, signed/unsigned per entry.
// 4x4 leaf products are merged pairwise per stage; the sign is applied in the last stage.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   iValid/oReady    input handshake; iA, iB, iSigned, iTag sampled on transfer
//   oValid/iReady    output handshake; oZ (2*DW product), oTag
//   oBusy            some stage holds a valid entry
module mult_pipe_dw #(
  parameter int DW = 16,
  parameter int TW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iValid,
  output logic            oReady,
  input  logic [DW-1:0]   iA,
  input  logic [DW-1:0]   iB,
  input  logic            iSigned,
  input  logic [TW-1:0]   iTag,
  output logic            oValid,
  input  logic            iReady,
  output logic [2*DW-1:0] oZ,
  output logic [TW-1:0]   oTag,
  output logic            oBusy
);

  localparam int LAT = $clog2(DW) - 1;
  // merge levels after the leaf stage; the last one feeds oZ
  localparam int NL  = LAT - 1;

  if (!(DW == 8 || DW == 16 || DW == 32 || DW == 64)) begin : g_bad_dw
    $error("mult_pipe_dw: DW must be 8, 16, 32 or 64");
  end

  logic adv;
  logic acc;

  // the whole pipe moves only when the output slot is free or draining
  assign adv    = !oValid | iReady;
  assign oReady = adv & !reset;
  assign acc    = iValid & oReady;

  logic          sa;
  logic          sb;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;

  // magnitude of -2^(DW-1) is 2^(DW-1), which still fits DW unsigned bits
  assign sa    = iSigned & iA[DW-1];
  assign sb    = iSigned & iB[DW-1];
  assign mag_a = sa ? -iA : iA;
  assign mag_b = sb ? -iB : iB;

  logic [LAT-1:0] v_q;
  logic [TW-1:0]  tag_q [LAT];
  logic           neg_q [LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= '0;
      end
      for (int k = 0; k < LAT - 1; k++) begin
        neg_q[k] <= 1'b0;
      end
    end else if (adv) begin
      v_q      <= {v_q[LAT-2:0], acc};
      tag_q[0] <= iTag;
      neg_q[0] <= sa ^ sb;
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      for (int k = 1; k < LAT - 1; k++) begin
        neg_q[k] <= neg_q[k-1];
      end
    end
  end

  for (genvar l = 0; l <= NL; l++) begin : g_lvl
    // level l holds NB x NB products of S-bit operand blocks
    localparam int S  = 4 << l;
    localparam int NB = DW / S;
    localparam int PW = 2 * S;

    logic [PW-1:0] prod_d [NB*NB];
    logic [PW-1:0] prod_q [NB*NB];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NB; i++) begin : g_i
        for (genvar j = 0; j < NB; j++) begin : g_j
          assign prod_d[i*NB+j] =
            {4'b0, mag_a[4*i +: 4]} *
            {4'b0, mag_b[4*j +: 4]};
        end
      end
    end else begin : g_merge
      localparam int SP  = S / 2;
      localparam int NBP = 2 * NB;
      for (genvar i = 0; i < NB; i++) begin : g_i
        for (genvar j = 0; j < NB; j++) begin : g_j
          logic [PW-1:0] ll;
          logic [PW-1:0] hl;
          logic [PW-1:0] lh;
          logic [PW-1:0] hh;
          logic [PW-1:0] mid;
          logic [PW-1:0] sum;

          // {A half, B half}: lo/lo, hi/lo, lo/hi, hi/hi
          assign ll  = {{S{1'b0}},
            g_lvl[l-1].prod_q[(2*i)*NBP + 2*j]};
          assign hl  = {{S{1'b0}},
            g_lvl[l-1].prod_q[(2*i+1)*NBP + 2*j]};
          assign lh  = {{S{1'b0}},
            g_lvl[l-1].prod_q[(2*i)*NBP + 2*j+1]};
          assign hh  = {{S{1'b0}},
            g_lvl[l-1].prod_q[(2*i+1)*NBP + 2*j+1]};
          assign mid = hl + lh;
          assign sum = ll + (mid << SP) + (hh << S);

          if (l == NL) begin : g_last
            assign prod_d[i*NB+j] =
              neg_q[LAT-2] ? -sum : sum;
          end else begin : g_mid
            assign prod_d[i*NB+j] = sum;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < NB*NB; k++) begin
          prod_q[k] <= '0;
        end
      end else if (adv) begin
        prod_q <= prod_d;
      end
    end
  end

  assign oZ     = g_lvl[NL].prod_q[0];
  assign oTag   = tag_q[LAT-1];
  assign oValid = v_q[LAT-1];
  assign oBusy  = |v_q;

endmodule

// File: tb/tb_mult_pipe_dw.sv
// tb_mult_pipe_dw: drives DW=8/16/32/64 instances of mult_pipe_dw.
// A negedge scoreboard checks products, order, output hold and oReady.
module tb_mult_pipe_dw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [3:0]       iv;
  logic [3:0]       ir;
  logic [3:0]       sg;
  logic [3:0][63:0] a_i;
  logic [3:0][63:0] b_i;
  logic [3:0][3:0]  tg;

  wire  [3:0]        ordy;
  wire  [3:0]        ov;
  wire  [3:0]        busy;
  wire  [3:0][127:0] z;
  wire  [3:0][3:0]   ot;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W = 8 << k;
    logic [2*W-1:0] zk;
    mult_pipe_dw #(.DW(W), .TW(4)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .iValid  (iv[k]),
      .oReady  (ordy[k]),
      .iA      (a_i[k][W-1:0]),
      .iB      (b_i[k][W-1:0]),
      .iSigned (sg[k]),
      .iTag    (tg[k]),
      .oValid  (ov[k]),
      .iReady  (ir[k]),
      .oZ      (zk),
      .oTag    (ot[k]),
      .oBusy   (busy[k])
    );
    assign z[k] = 128'(zk);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // width-w product from the arithmetic definition
  function automatic logic [127:0] ref_mul(input int k,
                                           input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic s);
    int w;
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] m;
    w  = 8 << k;
    ea = {64'd0, a} << (128 - w);
    eb = {64'd0, b} << (128 - w);
    if (s) begin
      ea = $signed(ea) >>> (128 - w);
      eb = $signed(eb) >>> (128 - w);
    end else begin
      ea = ea >> (128 - w);
      eb = eb >> (128 - w);
    end
    if (w == 64) m = '1;
    else m = (128'd1 << (2 * w)) - 128'd1;
    return (ea * eb) & m;
  endfunction

  typedef struct packed {
    logic [1:0]   k;
    logic [127:0] z;
    logic [3:0]   t;
  } exp_t;

  exp_t              sb[$];
  bit                mon_en = 1'b0;
  int                rx_cnt = 0;
  logic [3:0]        hold = '0;
  logic [3:0][127:0] hz;
  logic [3:0][3:0]   ht;

  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("ordy", ordy[k], !reset && !(ov[k] && !ir[k]));
        if (hold[k]) begin
          chk("hold_z", z[k], hz[k]);
          chk("hold_t", ot[k], ht[k]);
        end
        if (!reset && ov[k] && ir[k]) begin
          if (sb.size() == 0) begin
            chk("sb_extra", ov[k], 0);
          end else begin
            e = sb.pop_front();
            chk("sb_inst", k, e.k);
            chk("sb_z", z[k], e.z);
            chk("sb_t", ot[k], e.t);
            rx_cnt++;
          end
        end
        if (iv[k] && ordy[k]) begin
          n.k = 2'(k);
          n.z = ref_mul(k, a_i[k], b_i[k], sg[k]);
          n.t = tg[k];
          sb.push_back(n);
        end
        hold[k] = !reset && ov[k] && !ir[k];
        hz[k]   = z[k];
        ht[k]   = ot[k];
      end
      if (reset) sb.delete();
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    iv  = '0;
    ir  = '1;
    sg  = '0;
    a_i = '0;
    b_i = '0;
    tg  = '0;
  endtask

  logic [7:0]  sc_a [4] = '{8'h80, 8'hFF, 8'hFF, 8'h7F};
  logic [7:0]  sc_b [4] = '{8'h80, 8'h02, 8'h02, 8'h81};
  logic        sc_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  // 127 * -127 = -16129 -> 0xC0FF
  logic [15:0] sc_z [4] = '{16'h4000, 16'hFFFE, 16'h01FE, 16'hC0FF};

  initial begin
    int sent;
    int low_left;
    int rx_base;
    bit have;
    bit ev;

    // reset held 3 clocks with iValid high
    reset = 1'b1;
    idle();
    iv[1]  = 1'b1;
    a_i[1] = 64'h1234;
    b_i[1] = 64'h5678;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) mon_en = 1'b1;
      chk("rst_ov", ov[1], 0);
      chk("rst_busy", busy[1], 0);
      chk("rst_ordy", ordy[1], 0);
    end
    reset = 1'b0;
    iv[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("post_rst_ov", ov[1], 0);
    end

    // unsigned latency, DW=16
    iv[1]  = 1'b1;
    a_i[1] = 64'hFFFF;
    b_i[1] = 64'hFFFF;
    sg[1]  = 1'b0;
    tg[1]  = 4'h5;
    tick();
    iv[1] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("lat_ov", ov[1], c == 3);
      if (c == 3) begin
        chk("lat_z", z[1], 128'hFFFE0001);
        chk("lat_t", ot[1], 4'h5);
      end
      tick();
    end
    idle();
    repeat (4) tick();

    // signed corners, DW=8, back to back
    for (int c = 0; c <= 6; c++) begin
      chk("sc_ov", ov[0], c >= 2 && c <= 5);
      if (c >= 2 && c <= 5) chk("sc_z", z[0], 128'(sc_z[c-2]));
      if (c < 4) begin
        iv[0]  = 1'b1;
        a_i[0] = {56'd0, sc_a[c]};
        b_i[0] = {56'd0, sc_b[c]};
        sg[0]  = sc_s[c];
        tg[0]  = 4'(c);
      end else begin
        iv[0] = 1'b0;
      end
      tick();
    end
    idle();
    repeat (4) tick();

    // backpressure, DW=32
    sent     = 0;
    have     = 1'b0;
    low_left = 0;
    rx_base  = rx_cnt;
    for (int cyc = 0; cyc < 600 && rx_cnt - rx_base < 20; cyc++) begin
      if (low_left == 0 && $urandom_range(0, 2) == 0)
        low_left = $urandom_range(1, 6);
      ir[2] = (low_left == 0);
      if (low_left > 0) low_left--;
      if (!have && sent < 20 && $urandom_range(0, 4) != 0) begin
        a_i[2] = {32'd0, $urandom};
        b_i[2] = {32'd0, $urandom};
        sg[2]  = 1'($urandom_range(0, 1));
        tg[2]  = 4'($urandom);
        have   = 1'b1;
      end
      iv[2] = have;
      @(negedge clk);
      if (iv[2] && ordy[2]) begin
        have = 1'b0;
        sent++;
      end
      tick();
    end
    idle();
    repeat (8) tick();
    chk("bp_sent", sent, 20);
    chk("bp_rx", rx_cnt - rx_base, 20);
    chk("bp_sb_empty", sb.size(), 0);

    // reset with a full stalled pipe, DW=64
    ir[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iv[3]  = 1'b1;
      a_i[3] = {$urandom, $urandom};
      b_i[3] = {$urandom, $urandom};
      sg[3]  = 1'($urandom_range(0, 1));
      tg[3]  = 4'(c);
      tick();
    end
    iv[3] = 1'b0;
    chk("ms_full_busy", busy[3], 1);
    chk("ms_full_ov", ov[3], 1);
    chk("ms_full_ordy", ordy[3], 0);
    reset = 1'b1;
    tick();
    chk("ms_busy", busy[3], 0);
    chk("ms_ov", ov[3], 0);
    reset  = 1'b0;
    ir[3]  = 1'b1;
    iv[3]  = 1'b1;
    a_i[3] = 64'd3;
    b_i[3] = 64'd5;
    sg[3]  = 1'b0;
    tg[3]  = 4'h9;
    tick();
    iv[3] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk("ms_ov_after", ov[3], c == 5);
      if (c == 5) begin
        chk("ms_z", z[3], 128'd15);
        chk("ms_t", ot[3], 4'h9);
      end
      tick();
    end
    idle();
    repeat (8) tick();

    // throughput, DW=16
    for (int c = 0; c <= 104; c++) begin
      ev = (c >= 3 && c <= 102);
      chk("tp_ov", ov[1], ev);
      if (ev) chk("tp_z", z[1], 128'((c - 3) * (c - 2)));
      if (c == 102) chk("tp_busy_hi", busy[1], 1);
      if (c == 103) chk("tp_busy_lo", busy[1], 0);
      if (c < 100) begin
        iv[1]  = 1'b1;
        a_i[1] = 64'(c);
        b_i[1] = 64'(c + 1);
        sg[1]  = 1'b0;
        tg[1]  = 4'(c);
      end else begin
        iv[1] = 1'b0;
      end
      tick();
    end
    idle();
    repeat (4) tick();
    chk("end_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
